add_serial_feeder: RTL and testbench
====================================

ADD_SERIAL_FEEDER -- requirements
Module: add_serial_feeder

Interface
REQ-001 Parameter DEPTH, default 4: operand-FIFO entries; power of two, 2..16.
REQ-002 Parameter LAT, default 10: cycles from adder enable pulse to result capture; legal range 10..15.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  operand pair offered.
REQ-006 in_ready  output  1  FIFO can accept a pair.
REQ-007 in_a  input  8  operand A.
REQ-008 in_b  input  8  operand B.
REQ-009 add_en  output  1  one-cycle start pulse to the downstream serial adder.
REQ-010 add_a  output  8  operand A to the adder.
REQ-011 add_b  output  8  operand B to the adder.
REQ-012 add_out  input  8  serial-adder result bus.
REQ-013 res_valid  output  1  captured sum available.
REQ-014 res_ready  input  1  consumer accepts the sum.
REQ-015 res_data  output  8  captured sum, modulo 256.
REQ-016 busy  output  1  high whenever state is not IDLE or the FIFO is non-empty.

Function
REQ-017 FIFO push occurs on in_valid && in_ready; in_ready is 1 exactly when occupancy < DEPTH, independent of any same-cycle pop.
REQ-018 FIFO order is strict first-in first-out; read/write pointers wrap modulo DEPTH.
REQ-019 FSM states: IDLE, ISSUE, WAIT, HOLD.
REQ-020 IDLE -> ISSUE on the next edge when the FIFO is non-empty; otherwise remain IDLE.
REQ-021 In ISSUE: add_en = 1, add_a/add_b = FIFO head, head popped on this edge; ISSUE -> WAIT unconditionally.
REQ-022 add_a/add_b hold the last issued operands in all other states; add_en is 0 outside ISSUE.
REQ-023 WAIT: cycle counter starts at 1 on entry, increments each cycle; at count == LAT, add_out is registered into res_data and the state moves to HOLD.
REQ-024 HOLD: res_valid = 1, res_data stable; on res_ready = 1 -> IDLE; otherwise remain HOLD.
REQ-025 res_valid is 0 in every state except HOLD; res_ready is ignored outside HOLD.
REQ-026 Minimum issue spacing: LAT + 3 cycles (ISSUE, LAT WAIT cycles, HOLD, IDLE); this guarantees the adder returns to its idle state before the next pulse.
REQ-027 Push while in any FSM state is permitted; a push into an empty FIFO while in IDLE is issued one cycle later.
REQ-028 Latency, empty pipe, res_ready held high: in handshake at edge N -> add_en high in cycle N+2 -> res_valid high in cycle N+3+LAT.
REQ-029 Arithmetic is not performed here; res_data equals add_out exactly, including wrap (carry-out discarded by the adder).

Reset
REQ-030 On rst: state = IDLE, FIFO empty (pointers and count 0), wait counter 0.
REQ-031 Reset output values: in_ready = 1, add_en = 0, add_a = 0, add_b = 0, res_valid = 0, res_data = 0, busy = 0.
REQ-032 Reset asserted mid-operation (ISSUE/WAIT/HOLD) discards the in-flight sum and all queued pairs; no res_valid pulse follows.

Structure
REQ-033 Package add_serial_pkg holds the FSM state encoding (2-bit: IDLE=0, ISSUE=1, WAIT=2, HOLD=3) and the default DEPTH and LAT constants.
REQ-034 Operand storage is a sub-module add_op_fifo (16-bit entries {a,b}, DEPTH parameter, push/pop/full/empty/head ports); FSM and capture logic live in add_serial_feeder.

Verification
REQ-035 Single op: push a=0x35,b=0x4A; adder model returns 0x7F -> add_en one cycle, add_a=0x35, add_b=0x4A, res_valid at N+3+LAT with res_data=0x7F.
REQ-036 Wrap: push a=0xFF,b=0x01 -> res_data=0x00.
REQ-037 Backpressure: hold res_ready=0, push 5 pairs back-to-back -> in_ready falls after the 5th push (1 issued + 4 queued); res_data stable throughout HOLD.
REQ-038 Ordering: queue (0x01,0x02),(0x10,0x20),(0x80,0x80) -> results 0x03, 0x30, 0x00 in order, add_en pulses spaced exactly LAT+3 cycles.
REQ-039 Reset mid-WAIT at count 5 -> all outputs return to reset values; no res_valid pulse afterward; subsequent push operates normally.
REQ-040 Simultaneous push and pop with FIFO full -> push refused (in_ready=0 that cycle), no entry lost or duplicated.

Source files
------------

// File: rtl/add_serial_pkg.sv
// Shared types and defaults for the serial-adder operand feeder.
// State encoding is fixed so the FSM can be probed by downstream debug logic.
package add_serial_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam int DEFAULT_DEPTH = 4;
    localparam int DEFAULT_LAT   = 10;
    localparam int OP_W          = 8;
    localparam int ENTRY_W       = 2 * OP_W;
    localparam int CNT_W         = 4;

endpackage

// File: rtl/add_op_fifo.sv
// Operand-pair FIFO: entries are {a,b}; refuses pushes when full and pops when empty.
// Head is the oldest entry, read combinationally from the storage array.
module add_op_fifo
    import add_serial_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic               pop,
    input  logic [ENTRY_W-1:0] wdata,
    output logic [ENTRY_W-1:0] head,
    output logic               full,
    output logic               empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W:0]     count;
    logic               do_push;
    logic               do_pop;

    assign full    = (count == (PTR_W + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // NOTE: storage has no reset; the pointers and count alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // Power-of-two depth lets the pointers wrap by plain overflow.
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/add_serial_feeder.sv
// Feeds queued operand pairs one at a time to a fixed-latency serial adder,
// captures its result after LAT cycles and holds it until the consumer takes it.
module add_serial_feeder
    import add_serial_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int LAT   = DEFAULT_LAT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OP_W-1:0] in_a,
    input  logic [OP_W-1:0] in_b,
    output logic            add_en,
    output logic [OP_W-1:0] add_a,
    output logic [OP_W-1:0] add_b,
    input  logic [OP_W-1:0] add_out,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [OP_W-1:0] res_data,
    output logic            busy
);

    state_t              state;
    state_t              state_next;
    logic [CNT_W-1:0]    wait_cnt;
    logic [OP_W-1:0]     op_a;
    logic [OP_W-1:0]     op_b;
    logic [OP_W-1:0]     res_q;
    logic [ENTRY_W-1:0]  fifo_head;
    logic                fifo_full;
    logic                fifo_empty;
    logic                wait_done;

    add_op_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_valid && in_ready),
        .pop   (state == ISSUE),
        .wdata ({in_a, in_b}),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign wait_done = (wait_cnt == CNT_W'(LAT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: state_next gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (!fifo_empty) state_next = ISSUE;
            ISSUE: state_next = WAIT;
            WAIT:  if (wait_done) state_next = HOLD;
            HOLD:  if (res_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operands are latched on the IDLE->ISSUE edge so add_a/add_b come straight from flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a     <= '0;
            op_b     <= '0;
            res_q    <= '0;
            wait_cnt <= '0;
        end else begin
            if (state == IDLE && !fifo_empty) begin
                {op_a, op_b} <= fifo_head;
            end
            case (state)
                ISSUE: wait_cnt <= CNT_W'(1);
                WAIT: begin
                    if (wait_done) begin
                        res_q    <= add_out;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                default: wait_cnt <= wait_cnt;
            endcase
        end
    end

    always_comb begin
        add_en    = (state == ISSUE);
        res_valid = (state == HOLD);
        in_ready  = !fifo_full;
        busy      = (state != IDLE) || !fifo_empty;
        add_a     = op_a;
        add_b     = op_b;
        res_data  = res_q;
    end

endmodule

// File: tb/tb_add_serial_feeder.sv
// Scoreboard bench for add_serial_feeder with a behavioural fixed-latency adder.
// Expected operands/sums are queued at handshake and retired when the DUT issues/presents them.
module tb_add_serial_feeder;

    localparam int DEPTH = 4;
    localparam int LAT   = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic       add_en;
    logic [7:0] add_a;
    logic [7:0] add_b;
    logic [7:0] add_out;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic       busy;

    add_serial_feeder #(
        .DEPTH (DEPTH),
        .LAT   (LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .add_en    (add_en),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_out   (add_out),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Adder model: result appears on add_out only in the cycle the feeder must capture it.
    int         adder_k = 0;
    logic [7:0] adder_sum = 8'h00;

    always @(posedge clk) begin
        if (rst) begin
            adder_k <= 0;
        end else if (add_en) begin
            adder_k   <= 1;
            adder_sum <= add_a + add_b;
        end else if (adder_k != 0 && adder_k < 64) begin
            adder_k <= adder_k + 1;
        end
    end

    assign add_out = (adder_k == LAT) ? adder_sum : (adder_sum ^ 8'h5A);

    // Scoreboard
    logic [15:0] op_q [$];
    logic [7:0]  res_q [$];
    logic [15:0] mon_e;
    bit          prev_en    = 1'b0;
    bit          prev_valid = 1'b0;
    bit          spacing_en = 1'b0;
    int          last_issue = -1;
    int          en_cyc     = 0;
    int          rise_cyc   = 0;
    int          hs_cyc     = 0;

    always @(negedge clk) begin
        if (rst) begin
            prev_en    = 1'b0;
            prev_valid = 1'b0;
        end else begin
            if (add_en) begin
                check("en_pulse", prev_en, 1'b0);
                if (op_q.size() == 0) begin
                    check("en_unexpected", add_en, 1'b0);
                end else begin
                    mon_e = op_q.pop_front();
                    check("add_a", add_a, mon_e[15:8]);
                    check("add_b", add_b, mon_e[7:0]);
                    res_q.push_back(mon_e[15:8] + mon_e[7:0]);
                end
                if (spacing_en && last_issue >= 0) check("spacing", cyc - last_issue, LAT + 3);
                last_issue = cyc;
                en_cyc     = cyc;
            end
            prev_en = add_en;
            if (res_valid) begin
                if (!prev_valid) begin
                    check("res_latency", cyc - en_cyc, LAT + 1);
                    rise_cyc = cyc;
                end
                if (res_q.size() == 0) begin
                    check("res_unexpected", res_valid, 1'b0);
                end else begin
                    check("res_data", res_data, res_q[0]);
                    if (res_ready) void'(res_q.pop_front());
                end
            end
            prev_valid = res_valid;
        end
    end

    // Inputs change only 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] a, input logic [7:0] b, output int waits);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        waits    = 0;
        while (!in_ready && waits < 200) begin
            step();
            waits++;
        end
        if (!in_ready) begin
            check("push_timeout", in_ready, 1'b1);
        end else begin
            step();
            op_q.push_back({a, b});
            hs_cyc = cyc;
        end
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((op_q.size() != 0 || res_q.size() != 0 || busy) && t < 1000) begin
            step();
            t++;
        end
        check("drain_busy", busy, 1'b0);
        check("drain_queues", op_q.size() + res_q.size(), 0);
    endtask

    task automatic wait_issue();
        int t = 0;
        while (!add_en && t < 200) begin
            step();
            t++;
        end
        check("issue_seen", add_en, 1'b1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},  in_ready,  1'b1);
        check({tag, "_add_en"},    add_en,    1'b0);
        check({tag, "_add_a"},     add_a,     8'h00);
        check({tag, "_add_b"},     add_b,     8'h00);
        check({tag, "_res_valid"}, res_valid, 1'b0);
        check({tag, "_res_data"},  res_data,  8'h00);
        check({tag, "_busy"},      busy,      1'b0);
    endtask

    initial begin
        int w;
        int seen;
        logic [7:0] ra;
        logic [7:0] rb;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = 8'h00;
        in_b      = 8'h00;
        res_ready = 1'b1;
        step();
        step();
        check_reset_outputs("reset");
        rst = 1'b0;
        step();

        // Single operation with end-to-end latency
        push(8'h35, 8'h4A, w);
        idle();
        drain();
        check("lat_issue", en_cyc - hs_cyc, 1);
        check("lat_result", rise_cyc - hs_cyc, LAT + 2);
        check("single_res", res_data, 8'h7F);

        // Carry-out wrap
        push(8'hFF, 8'h01, w);
        idle();
        drain();
        check("wrap_res", res_data, 8'h00);

        // Backpressure: one issued plus DEPTH queued
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("bp_ready", in_ready, 1'b1);
            push(8'(8'h13 + i * 8'h11), 8'(i + 1), w);
            check("bp_nowait", w, 0);
        end
        idle();
        check("bp_full", in_ready, 1'b0);
        check("bp_busy", busy, 1'b1);
        repeat (LAT + 6) step();
        check("bp_hold", res_valid, 1'b1);

        // Push offered while full, during the pop cycle: must be refused then accepted later
        in_valid  = 1'b1;
        in_a      = 8'hAA;
        in_b      = 8'hBB;
        res_ready = 1'b1;
        wait_issue();
        check("full_pop_ready", in_ready, 1'b0);
        push(8'hAA, 8'hBB, w);
        idle();
        drain();

        // Ordering with exact issue spacing
        spacing_en = 1'b1;
        last_issue = -1;
        push(8'h01, 8'h02, w);
        push(8'h10, 8'h20, w);
        push(8'h80, 8'h80, w);
        idle();
        drain();
        check("order_last", res_data, 8'h00);
        spacing_en = 1'b0;

        // Reset in the middle of WAIT
        push(8'h11, 8'h22, w);
        push(8'h33, 8'h44, w);
        push(8'h55, 8'h66, w);
        idle();
        wait_issue();
        repeat (5) step();
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        op_q.delete();
        res_q.delete();
        step();
        step();
        rst  = 1'b0;
        seen = 0;
        for (int i = 0; i < LAT + 10; i++) begin
            step();
            if (res_valid || add_en) seen++;
        end
        check("post_rst_quiet", seen, 0);
        push(8'h20, 8'h22, w);
        idle();
        drain();
        check("post_rst_res", res_data, 8'h42);

        // A few random pairs
        for (int i = 0; i < 3; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            push(ra, rb, w);
        end
        idle();
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
